// File: rtl/main_pkg.sv
// rtl/main_pkg.sv - shared widths and opcode encodings for main
package main_pkg;

  localparam int DATA_W = 8;
  localparam int MEM_AW = 4;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_LDIDX = 4'h2;
  localparam logic [3:0] OP_WRITE = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_XOR   = 4'h9;
  localparam logic [3:0] OP_READ  = 4'hA;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/main_alu.sv
// rtl/main_alu.sv - combinational ALU for ADD..XOR producing result, carry/borrow and zero
import main_pkg::*;

module main_alu (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o,
  output logic              c_o,
  output logic              z_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    res_o = a_i;
    c_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o = sum[DATA_W-1:0];
        c_o   = sum[DATA_W];
      end
      OP_SUB: begin
        res_o = a_i - b_i;
        c_o   = (a_i < b_i);
      end
      OP_NOT:  res_o = ~a_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      default: res_o = a_i;
    endcase
    z_o = (res_o == '0);
  end

endmodule

// File: rtl/main.sv
// rtl/main.sv - switch-driven accumulator machine: strobe synchroniser, decoder, registers
// Optional 16x8 memory with WRITE/READ is built only when MAIN_MEM_EN is defined.
import main_pkg::*;

module main (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       SW5,
  input  logic       SW6,
  input  logic       SW7,
  input  logic       SW8,
  input  logic       SW17,
  input  logic       SW18,
  input  logic       SW22,
  output logic [7:0] DOUT,
  output logic       SIG1,
  output logic       SIG2
);

  logic [3:0]        opcode;
  logic [3:0]        imm4;
  logic              sync1_q, sync2_q, edge_q;
  logic [1:0]        vld_q;
  logic              armed_q, armed_d;
  logic              exec;
  logic [DATA_W-1:0] acc_q, acc_d, idx_q, idx_d;
  logic              c_q, c_d, z_q, z_d;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_z;

  assign opcode = {SW1, SW2, SW3, SW4};
  assign imm4   = {SW5, SW6, SW7, SW8};

  // Arm only after the synchronised strobe has been seen low, so a level held through reset never fires.
  assign armed_d = armed_q | (vld_q[1] & ~sync2_q);
  assign exec    = armed_q & sync2_q & ~edge_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= SW17;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  main_alu u_alu (
    .op_i  (opcode),
    .a_i   (acc_q),
    .b_i   (idx_q),
    .res_o (alu_res),
    .c_o   (alu_c),
    .z_o   (alu_z)
  );

`ifdef MAIN_MEM_EN
  logic [DATA_W-1:0] mem_q [1<<MEM_AW];
  logic [DATA_W-1:0] mem_rd;

  assign mem_rd = mem_q[idx_q[MEM_AW-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < (1 << MEM_AW); i++) mem_q[i] <= '0;
    end else if (exec && opcode == OP_WRITE) begin
      mem_q[idx_q[MEM_AW-1:0]] <= acc_q;
    end
  end
`endif

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    c_d   = c_q;
    z_d   = z_q;
    if (exec) begin
      case (opcode)
        OP_LOADI: acc_d = {4'h0, imm4};
        OP_LDIDX: idx_d = acc_q;
`ifdef MAIN_MEM_EN
        OP_READ:  acc_d = mem_rd;
`endif
        default: begin
          if (is_alu_op(opcode)) begin
            acc_d = alu_res;
            c_d   = alu_c;
            z_d   = alu_z;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q <= '0;
      idx_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      c_q   <= c_d;
      z_q   <= z_d;
    end
  end

  always_comb begin
    DOUT = 8'h00;
    if (SW22) DOUT = SW18 ? acc_q : idx_q;
  end

  assign SIG1 = c_q;
  assign SIG2 = z_q;

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - directed self-checking bench for main
import main_pkg::*;

module tb_main;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SW1 = 0, SW2 = 0, SW3 = 0, SW4 = 0, SW5 = 0, SW6 = 0, SW7 = 0, SW8 = 0;
  logic       SW17 = 1'b0;
  logic       SW18 = 1'b1;
  logic       SW22 = 1'b1;
  logic [7:0] DOUT;
  logic       SIG1, SIG2;

  int n_cmp  = 0;
  int n_fail = 0;

  main dut (
    .CLK(CLK), .RST(RST),
    .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
    .SW5(SW5), .SW6(SW6), .SW7(SW7), .SW8(SW8),
    .SW17(SW17), .SW18(SW18), .SW22(SW22),
    .DOUT(DOUT), .SIG1(SIG1), .SIG2(SIG2)
  );

  always #5 CLK = ~CLK;

  task automatic set_instr(input logic [3:0] op, input logic [3:0] imm);
    {SW1, SW2, SW3, SW4} = op;
    {SW5, SW6, SW7, SW8} = imm;
  endtask

  task automatic exec(input logic [3:0] op, input logic [3:0] imm);
    @(negedge CLK);
    set_instr(op, imm);
    repeat (3) @(negedge CLK);
    SW17 = 1'b1;
    repeat (5) @(negedge CLK);
    SW17 = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic read_regs(output logic [7:0] acc, output logic [7:0] idx);
    SW22 = 1'b1;
    SW18 = 1'b1; #1 acc = DOUT;
    SW18 = 1'b0; #1 idx = DOUT;
    SW18 = 1'b1; #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (DOUT !== 8'h00 || SIG1 !== 1'b0 || SIG2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h c=%b z=%b want 00 0 0", DOUT, SIG1, SIG2);
    end
    RST = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_loadi_display;
    exec(OP_LOADI, 4'hD);
    exec(OP_LDIDX, 4'h0);
    exec(OP_LOADI, 4'h7);
    SW22 = 1'b1; SW18 = 1'b1; #1;
    n_cmp++;
    if (DOUT !== 8'h07) begin n_fail++; $display("FAIL disp_acc: got %h want 07", DOUT); end
    SW18 = 1'b0; #1;
    n_cmp++;
    if (DOUT !== 8'h0D) begin n_fail++; $display("FAIL disp_idx: got %h want 0D", DOUT); end
    SW18 = 1'b1; #1;
  endtask

  task automatic test_alu_seq;
    logic [3:0] ops [6];
    logic [7:0] exp_acc [6];
    logic       exp_c [6];
    logic       exp_z [6];
    logic [7:0] acc, idx;
    ops = '{OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR};
    exp_acc = '{8'h14, 8'h07, 8'hF8, 8'h08, 8'h0D, 8'h00};
    exp_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_z = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      exec(ops[i], 4'h0);
      read_regs(acc, idx);
      n_cmp++;
      if (acc !== exp_acc[i] || SIG1 !== exp_c[i] || SIG2 !== exp_z[i]) begin
        n_fail++;
        $display("FAIL alu_op%0h: got acc=%h c=%b z=%b want acc=%h c=%b z=%b",
                 ops[i], acc, SIG1, SIG2, exp_acc[i], exp_c[i], exp_z[i]);
      end
    end
  endtask

  task automatic test_borrow_carry;
    logic [7:0] acc, idx;
    exec(OP_SUB, 4'h0);
    read_regs(acc, idx);
    n_cmp++;
    if (acc !== 8'hF3 || SIG1 !== 1'b1 || SIG2 !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow: got acc=%h c=%b z=%b want F3 1 0", acc, SIG1, SIG2);
    end
    exec(OP_LOADI, 4'hF);
    n_cmp++;
    if (SIG1 !== 1'b1) begin n_fail++; $display("FAIL loadi_keeps_c: got %b want 1", SIG1); end
    exec(OP_NOT, 4'h0);
    exec(OP_LDIDX, 4'h0);
    exec(OP_ADD, 4'h0);
    read_regs(acc, idx);
    n_cmp++;
    if (acc !== 8'hE0 || idx !== 8'hF0 || SIG1 !== 1'b1 || SIG2 !== 1'b0) begin
      n_fail++;
      $display("FAIL add_carry: got acc=%h idx=%h c=%b z=%b want E0 F0 1 0", acc, idx, SIG1, SIG2);
    end
  endtask

  task automatic test_nop_display_off;
    logic [7:0] acc, idx;
    exec(4'hF, 4'h5);
    exec(OP_NOP, 4'hA);
    read_regs(acc, idx);
    n_cmp++;
    if (acc !== 8'hE0 || idx !== 8'hF0 || SIG1 !== 1'b1 || SIG2 !== 1'b0) begin
      n_fail++;
      $display("FAIL nop_no_change: got acc=%h idx=%h c=%b z=%b want E0 F0 1 0", acc, idx, SIG1, SIG2);
    end
    SW22 = 1'b0; SW18 = 1'b1; #1;
    n_cmp++;
    if (DOUT !== 8'h00) begin n_fail++; $display("FAIL disp_off_acc: got %h want 00", DOUT); end
    SW18 = 1'b0; #1;
    n_cmp++;
    if (DOUT !== 8'h00) begin n_fail++; $display("FAIL disp_off_idx: got %h want 00", DOUT); end
    SW22 = 1'b1; SW18 = 1'b1; #1;
  endtask

  task automatic test_mem;
    logic [7:0] acc, idx;
    exec(OP_LOADI, 4'hD);
    exec(OP_LDIDX, 4'h0);
    exec(OP_WRITE, 4'h0);
    exec(OP_LOADI, 4'h0);
    exec(OP_READ, 4'h0);
    read_regs(acc, idx);
`ifdef MAIN_MEM_EN
    n_cmp++;
    if (acc !== 8'h0D) begin n_fail++; $display("FAIL mem_read: got %h want 0D", acc); end
`else
    n_cmp++;
    if (acc !== 8'h00) begin n_fail++; $display("FAIL read_is_nop: got %h want 00", acc); end
`endif
  endtask

  task automatic test_hold;
    logic [7:0] acc, idx;
    exec(OP_LOADI, 4'h3);
    exec(OP_LDIDX, 4'h0);
    exec(OP_LOADI, 4'h1);
    @(negedge CLK);
    set_instr(OP_ADD, 4'h0);
    repeat (3) @(negedge CLK);
    SW17 = 1'b1;
    repeat (100) @(negedge CLK);
    SW17 = 1'b0;
    repeat (4) @(negedge CLK);
    read_regs(acc, idx);
    n_cmp++;
    if (acc !== 8'h04) begin n_fail++; $display("FAIL hold_single_exec: got %h want 04", acc); end
  endtask

  task automatic test_rst_midseq;
    logic [7:0] acc, idx;
    exec(OP_LOADI, 4'h9);
    @(negedge CLK);
    set_instr(OP_LOADI, 4'h5);
    repeat (3) @(negedge CLK);
    SW17 = 1'b1;
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (DOUT !== 8'h00 || SIG1 !== 1'b0 || SIG2 !== 1'b0) begin
      n_fail++; $display("FAIL rst_immediate: got dout=%h c=%b z=%b want 00 0 0", DOUT, SIG1, SIG2);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    read_regs(acc, idx);
    n_cmp++;
    if (acc !== 8'h00) begin n_fail++; $display("FAIL held_through_reset: got %h want 00", acc); end
    SW17 = 1'b0;
    repeat (4) @(negedge CLK);
    exec(OP_LOADI, 4'h6);
    read_regs(acc, idx);
    n_cmp++;
    if (acc !== 8'h06) begin n_fail++; $display("FAIL exec_after_reset: got %h want 06", acc); end
  endtask

  initial begin
    test_reset();
    test_loadi_display();
    test_alu_seq();
    test_borrow_carry();
    test_nop_display_off();
    test_rst_midseq();
    test_hold();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    test_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock, rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have ports SW1..SW8, input, 1 bit each: instruction byte, SW1 = MSB; {SW1..SW4} = opcode, {SW5..SW8} = imm4.
REQ-004 SHALL have port SW17, input, 1 bit: asynchronous execute strobe; a rising edge executes one instruction.
REQ-005 SHALL have port SW18, input, 1 bit: display select; 1 = ACC, 0 = IDX.
REQ-006 SHALL have port SW22, input, 1 bit: display enable; 0 forces DOUT = 0x00.
REQ-007 SHALL have port DOUT, output, 8 bits: selected register, combinational from registers and SW18/SW22.
REQ-008 SHALL have port SIG1, output, 1 bit: carry flag C.
REQ-009 SHALL have port SIG2, output, 1 bit: zero flag Z.

Function
REQ-010 SHALL synchronise SW17 through two flops, then edge-detect with a third flop, giving a one-cycle EXEC pulse.
REQ-011 SHALL update registers on the 3rd CLK rising edge after SW17 rises; SW1..SW8 SHALL be sampled on that same edge and must be stable for at least 3 cycles beforehand.
REQ-012 SHALL execute exactly once per SW17 rising edge; a SW17 falling edge or a held level SHALL do nothing.
REQ-013 SHALL use state of ACC[7:0], IDX[7:0], C, Z and a 16x8 memory MEM.
REQ-014 SHALL implement opcode 0x1 LOADI: ACC <= {4'h0, imm4}; flags unchanged.
REQ-015 SHALL implement opcode 0x2 LDIDX: IDX <= ACC.
REQ-016 SHALL implement opcode 0x3 WRITE: MEM[IDX[3:0]] <= ACC.
REQ-017 SHALL implement opcode 0x4 ADD: {C, ACC} <= ACC + IDX, as a 9-bit sum.
REQ-018 SHALL implement opcode 0x5 SUB: ACC <= ACC - IDX (mod 256); C <= 1 if and only if ACC < IDX (borrow).
REQ-019 SHALL implement opcodes 0x6 NOT (~ACC), 0x7 AND (ACC & IDX), 0x8 OR (ACC | IDX) and 0x9 XOR (ACC ^ IDX); each SHALL clear C.
REQ-020 SHALL implement opcode 0xA READ: ACC <= MEM[IDX[3:0]]; flags unchanged.
REQ-021 SHALL set Z <= (new ACC == 0) after opcodes 0x4-0x9 only.
REQ-022 SHALL treat opcodes 0x0 and 0xB-0xF as NOP, with no state change.
REQ-023 SHALL, when SW22 = 1, drive DOUT = SW18 ? ACC : IDX; SW18/SW22 changes SHALL appear on DOUT without clock delay.

Reset
REQ-024 SHALL asynchronously clear ACC, IDX, C, Z, all MEM words and all strobe flops while RST = 1; DOUT = 0x00, SIG1 = 0, SIG2 = 0.
REQ-025 SHALL NOT generate EXEC from the first clocks after RST release if SW17 is already high; only a subsequent 0->1 transition executes.
REQ-026 SHALL abort a SW17 edge still in the synchroniser when RST asserts, with no instruction executed.

Configuration
REQ-027 SHALL compile MEM, WRITE (0x3) and READ (0xA) in only when macro MAIN_MEM_EN is defined.
REQ-028 SHALL, without MAIN_MEM_EN, omit MEM and decode 0x3 and 0xA as NOP; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL place opcode localparams (OP_LOADI..OP_READ) and the widths DATA_W = 8 and MEM_AW = 4 in package main_pkg.
REQ-030 SHALL implement the combinational ALU (ADD..XOR, result plus C plus Z) as sub-module main_alu; main SHALL hold the synchroniser, decoder, registers and MEM.

Verification
REQ-031 SHALL verify: LOADI 0x1D, LDIDX, LOADI 0x17, with SW18 = 1 and SW22 = 1 -> DOUT = 0x07; with SW18 = 0 -> DOUT = 0x0D.
REQ-032 SHALL verify: continuing the sequence, ADD -> 0x14, C = 0, Z = 0; SUB -> 0x07; NOT -> 0xF8; AND -> 0x08; OR -> 0x0D; XOR -> 0x00 with Z = 1.
REQ-033 SHALL verify: ACC = 0x00, IDX = 0x0D, SUB -> ACC = 0xF3, C = 1; then LOADI 0xF, NOT, LDIDX, ADD (0xF0 + 0xF0) -> ACC = 0xE0, C = 1.
REQ-034 SHALL verify (MAIN_MEM_EN): WRITE with ACC = 0x0D, IDX = 0x0D; then LOADI 0; then READ -> ACC = 0x0D.
REQ-035 SHALL verify: SW17 held high for 100 cycles -> exactly one execution; RST pulse mid-sequence -> all outputs 0 immediately.
REQ-036 SHALL verify: SW22 = 0 -> DOUT = 0x00 regardless of ACC and IDX; opcode 0xF -> no register or flag change.
